pipe_stage_skid: RTL and testbench

PIPE_STAGE_SKID -- requirements
Module: pipe_stage_skid

---
 rtl/pipe_stage_skid_pkg.sv | 15 +
 rtl/pipe_stage_skid_sat_counter.sv | 23 ++
 rtl/pipe_stage_skid.sv | 120 ++++++++++++
 tb/tb_pipe_stage_skid.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_stage_skid_pkg.sv
// Shared pipeline package: default bundle widths and the skid-stage state encoding.
// Imported by the stage top and its counter sub-module.
package pipe_stage_skid_pkg;

  localparam int unsigned PAYLOAD_WIDTH_DEF = 128;
  localparam int unsigned CTRL_WIDTH_DEF    = 16;
  localparam int unsigned CNT_WIDTH_DEF     = 16;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_FULL  = 2'b10
  } skid_state_e;

endpackage : pipe_stage_skid_pkg

// File: rtl/pipe_stage_skid_sat_counter.sv
// Saturating up-counter: advances by one per enabled cycle and sticks at all-ones.
// Cleared only by the asynchronous reset.
module sat_counter
  import pipe_stage_skid_pkg::*;
#(
  parameter int CNT_WIDTH = CNT_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 inc,
  output logic [CNT_WIDTH-1:0] count
);

  // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + CNT_WIDTH'(1);
    end
  end

endmodule : sat_counter

// File: rtl/pipe_stage_skid.sv
// Two-entry (main + skid) valid/ready pipeline register with registered in_ready,
// synchronous flush and a saturating downstream-stall cycle counter.
module pipe_stage_skid
  import pipe_stage_skid_pkg::*;
#(
  parameter int PAYLOAD_WIDTH = PAYLOAD_WIDTH_DEF,
  parameter int CTRL_WIDTH    = CTRL_WIDTH_DEF,
  parameter int CNT_WIDTH     = CNT_WIDTH_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic [PAYLOAD_WIDTH-1:0] in_payload_i,
  input  logic [CTRL_WIDTH-1:0]    in_ctrl_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [PAYLOAD_WIDTH-1:0] out_payload_o,
  output logic [CTRL_WIDTH-1:0]    out_ctrl_o,
  input  logic                     flush_i,
  output logic [CNT_WIDTH-1:0]     stall_cnt_o
);

  skid_state_e              state_q, state_d;
  logic                     in_ready_q;
  logic [PAYLOAD_WIDTH-1:0] main_payload_q, skid_payload_q;
  logic [CTRL_WIDTH-1:0]    main_ctrl_q, skid_ctrl_q;

  logic in_fire, out_fire;
  logic load_main_in, load_main_skid, load_skid;

  assign out_valid_o   = (state_q == ST_ONE) || (state_q == ST_FULL);
  assign in_ready_o    = in_ready_q;
  assign in_fire       = in_valid_i && in_ready_q;
  assign out_fire      = out_valid_o && out_ready_i;
  assign out_payload_o = main_payload_q;
  assign out_ctrl_o    = out_valid_o ? main_ctrl_q : '0;

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d        = state_q;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    unique case (state_q)
      ST_EMPTY: begin
        if (in_fire) begin
          state_d      = ST_ONE;
          load_main_in = 1'b1;
        end
      end
      ST_ONE: begin
        if (in_fire && out_fire) begin
          load_main_in = 1'b1;
        end else if (out_fire) begin
          state_d = ST_EMPTY;
        end else if (in_fire) begin
          state_d   = ST_FULL;
          load_skid = 1'b1;
        end
      end
      ST_FULL: begin
        if (out_fire) begin
          state_d        = ST_ONE;
          load_main_skid = 1'b1;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    // Flush wins over any same-cycle transfer; nothing is written so the output payload holds.
    if (flush_i) begin
      state_d        = ST_EMPTY;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != ST_FULL);
    end
  end

  // NOTE: the entry registers are reset on purpose: outputs and the skid entry must read zero in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_payload_q <= '0;
      main_ctrl_q    <= '0;
      skid_payload_q <= '0;
      skid_ctrl_q    <= '0;
    end else begin
      if (load_main_in) begin
        main_payload_q <= in_payload_i;
        main_ctrl_q    <= in_ctrl_i;
      end else if (load_main_skid) begin
        main_payload_q <= skid_payload_q;
        main_ctrl_q    <= skid_ctrl_q;
      end
      if (load_skid) begin
        skid_payload_q <= in_payload_i;
        skid_ctrl_q    <= in_ctrl_i;
      end
    end
  end

  sat_counter #(
    .CNT_WIDTH(CNT_WIDTH)
  ) u_stall_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (out_valid_o && !out_ready_i),
    .count(stall_cnt_o)
  );

endmodule : pipe_stage_skid

// File: tb/tb_pipe_stage_skid.sv
// Scoreboard bench for pipe_stage_skid: directed stimulus pushes expected transfers,
// a negedge monitor pops and compares every downstream transfer.
module tb_pipe_stage_skid;

  localparam int PW = 128;
  localparam int CW = 16;
  localparam int NW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid_i;
  logic          in_ready_o;
  logic [PW-1:0] in_payload_i;
  logic [CW-1:0] in_ctrl_i;
  logic          out_valid_o;
  logic          out_ready_i;
  logic [PW-1:0] out_payload_o;
  logic [CW-1:0] out_ctrl_o;
  logic          flush_i;
  logic [NW-1:0] stall_cnt_o;

  typedef struct packed {
    logic [PW-1:0] p;
    logic [CW-1:0] c;
  } xfer_t;

  xfer_t exp_q[$];
  xfer_t mon_e;
  int    pass_cnt  = 0;
  int    total_cnt = 0;

  pipe_stage_skid #(
    .PAYLOAD_WIDTH(PW),
    .CTRL_WIDTH   (CW),
    .CNT_WIDTH    (NW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid_i   (in_valid_i),
    .in_ready_o   (in_ready_o),
    .in_payload_i (in_payload_i),
    .in_ctrl_i    (in_ctrl_i),
    .out_valid_o  (out_valid_o),
    .out_ready_i  (out_ready_i),
    .out_payload_o(out_payload_o),
    .out_ctrl_o   (out_ctrl_o),
    .flush_i      (flush_i),
    .stall_cnt_o  (stall_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp_v);
    total_cnt++;
    if (act === exp_v) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp_v);
  endtask

  function automatic logic [CW-1:0] ctrl_of(input logic [PW-1:0] p);
    return {8'hC0, p[7:0]};
  endfunction

  // Monitor: a transfer is visible mid-cycle and completes on the next rising edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid_o && out_ready_i) begin
        if (exp_q.size() == 0) begin
          total_cnt++;
          $display("FAIL unexpected_output: got 0x%0h, want no transfer", out_payload_o);
        end else begin
          mon_e = exp_q.pop_front();
          check("out_payload", out_payload_o, mon_e.p);
          check("out_ctrl", PW'(out_ctrl_o), PW'(mon_e.c));
        end
      end else if (!out_valid_o) begin
        check("bubble_ctrl", PW'(out_ctrl_o), '0);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic offer(input logic [PW-1:0] p, input bit expected);
    xfer_t e;
    in_valid_i   = 1'b1;
    in_payload_i = p;
    in_ctrl_i    = ctrl_of(p);
    if (expected) begin
      e.p = p;
      e.c = ctrl_of(p);
      exp_q.push_back(e);
    end
  endtask

  // Holds the current offer until the edge that accepts it (bounded).
  task automatic wait_accept();
    int   n = 0;
    logic rdy;
    do begin
      rdy = in_ready_o;
      @(posedge clk);
      #1;
      n++;
    end while (!rdy && n < 200);
    if (!rdy) begin
      total_cnt++;
      $display("FAIL accept_timeout: got no acceptance in %0d cycles, want acceptance", n);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no end of test, want $finish before 100us");
    $fatal(1);
  end

  initial begin
    rst_n        = 1'b0;
    in_valid_i   = 1'b0;
    in_payload_i = '0;
    in_ctrl_i    = '0;
    out_ready_i  = 1'b0;
    flush_i      = 1'b0;
    #12;
    check("rst_in_ready", PW'(in_ready_o), 1);
    check("rst_out_valid", PW'(out_valid_o), 0);
    check("rst_out_payload", out_payload_o, 0);
    check("rst_out_ctrl", PW'(out_ctrl_o), 0);
    check("rst_stall_cnt", PW'(stall_cnt_o), 0);
    rst_n = 1'b1;
    step(1);

    // Single transfer into EMPTY: visible exactly one cycle later.
    out_ready_i = 1'b1;
    offer(128'hA, 1'b1);
    wait_accept();
    in_valid_i = 1'b0;
    check("lat_out_valid", PW'(out_valid_o), 1);
    check("lat_out_payload", out_payload_o, 128'hA);
    check("lat_in_ready", PW'(in_ready_o), 1);
    step(1);
    check("lat_drained", PW'(out_valid_o), 0);
    check("hold_payload", out_payload_o, 128'hA);

    // Backpressure: two entries fill main+skid, the third waits upstream.
    out_ready_i = 1'b0;
    offer(128'h1, 1'b1);
    wait_accept();
    offer(128'h2, 1'b1);
    wait_accept();
    check("full_in_ready", PW'(in_ready_o), 0);
    offer(128'h3, 1'b1);
    step(2);
    check("full_hold_ready", PW'(in_ready_o), 0);
    check("full_out_valid", PW'(out_valid_o), 1);
    check("full_main", out_payload_o, 128'h1);
    out_ready_i = 1'b1;
    wait_accept();
    in_valid_i = 1'b0;
    step(3);
    check("order_drained", PW'(out_valid_o), 0);

    // Flush in FULL with an input presented: everything discarded.
    out_ready_i = 1'b0;
    offer(128'h21, 1'b1);
    wait_accept();
    offer(128'h22, 1'b1);
    wait_accept();
    offer(128'h23, 1'b0);
    flush_i = 1'b1;
    exp_q.delete();
    step(1);
    flush_i    = 1'b0;
    in_valid_i = 1'b0;
    check("flush_full_valid", PW'(out_valid_o), 0);
    check("flush_full_ctrl", PW'(out_ctrl_o), 0);
    check("flush_full_ready", PW'(in_ready_o), 1);
    check("flush_full_payload", out_payload_o, 128'h21);
    out_ready_i = 1'b1;
    step(3);

    // Flush in ONE while the input is accepted: the input must not be stored.
    out_ready_i = 1'b0;
    offer(128'h31, 1'b1);
    wait_accept();
    offer(128'h32, 1'b0);
    flush_i = 1'b1;
    exp_q.delete();
    step(1);
    flush_i    = 1'b0;
    in_valid_i = 1'b0;
    check("flush_one_valid", PW'(out_valid_o), 0);
    check("flush_one_payload", out_payload_o, 128'h31);
    out_ready_i = 1'b1;
    step(3);

    // Flush with a same-cycle output transfer: that entry still counts as delivered.
    offer(128'h41, 1'b1);
    wait_accept();
    offer(128'h42, 1'b0);
    flush_i = 1'b1;
    step(1);
    flush_i    = 1'b0;
    in_valid_i = 1'b0;
    check("flush_out_valid", PW'(out_valid_o), 0);
    step(2);

    // Streaming in ONE: ten back-to-back transfers with no bubble.
    out_ready_i = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      offer(PW'(i), 1'b1);
      wait_accept();
      check("stream_valid", PW'(out_valid_o), 1);
      check("stream_payload", out_payload_o, PW'(i));
    end
    in_valid_i = 1'b0;
    step(1);
    check("stream_drained", PW'(out_valid_o), 0);
    step(2);
    check("queue_drained", PW'(exp_q.size()), 0);

    // Stall counter: fresh reset, count, survive flush, saturate, async clear.
    rst_n = 1'b0;
    #3;
    exp_q.delete();
    rst_n = 1'b1;
    step(1);
    out_ready_i = 1'b0;
    offer(128'h55, 1'b1);
    wait_accept();
    in_valid_i = 1'b0;
    step(3);
    check("stall_cnt_3", PW'(stall_cnt_o), 3);
    flush_i = 1'b1;
    exp_q.delete();
    step(1);
    flush_i = 1'b0;
    check("stall_after_flush", PW'(stall_cnt_o), 4);
    offer(128'h66, 1'b1);
    wait_accept();
    in_valid_i = 1'b0;
    step((1 << NW) + 5);
    check("stall_saturated", PW'(stall_cnt_o), 15);
    check("stall_valid", PW'(out_valid_o), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_stall", PW'(stall_cnt_o), 0);
    check("async_rst_valid", PW'(out_valid_o), 0);
    check("async_rst_ready", PW'(in_ready_o), 1);
    check("async_rst_payload", out_payload_o, 0);
    exp_q.delete();
    #3;
    rst_n = 1'b1;
    step(3);
    check("post_rst_valid", PW'(out_valid_o), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule : tb_pipe_stage_skid
